// File: rtl/fetch_unit_if.sv
// fetch_unit_if: fetch-stage bus bundle.
//   ROM side     : IMEM_EN, IMEM_ADDR (to ROM), IMEM_DATA (from ROM, 1-cycle latency)
//   Decoder side : IR, PC, VALID (to decoder), STALL, HALT (from decoder)
//   Execute side : REDIRECT, REDIRECT_PC (from execute)
// master = fetch unit, slave = the surrounding pipeline / ROM.
interface fetch_unit_if;
  logic        IMEM_EN;
  logic [10:0] IMEM_ADDR;
  logic [31:0] IMEM_DATA;
  logic [31:0] IR;
  logic [10:0] PC;
  logic        VALID;
  logic        STALL;
  logic        HALT;
  logic        REDIRECT;
  logic [10:0] REDIRECT_PC;

  modport master (
    output IMEM_EN, IMEM_ADDR, IR, PC, VALID,
    input  IMEM_DATA, STALL, HALT, REDIRECT, REDIRECT_PC
  );

  modport slave (
    input  IMEM_EN, IMEM_ADDR, IR, PC, VALID,
    output IMEM_DATA, STALL, HALT, REDIRECT, REDIRECT_PC
  );
endinterface

// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch stage feeding the decoder.
//   CLK  : clock, rising edge
//   RST  : synchronous active-high reset
//   bus  : fetch_unit_if.master (ROM read port, decoder IR/PC/VALID with
//          STALL/HALT back-pressure, execute-stage REDIRECT)
// Keeps the fetch PC, issues reads to a 1-cycle-latency ROM, and buffers one
// returning instruction in a skid entry so a decoder stall never loses data.
module fetch_unit #(
  parameter logic [10:0] RESET_PC = 11'd0
) (
  input  logic         CLK,
  input  logic         RST,
  fetch_unit_if.master bus
);

  typedef enum logic {S_RUN, S_WAIT} state_t;

  state_t      state_q, state_nxt;
  logic [10:0] fpc;
  logic        req_v;
  logic [10:0] req_pc;
  logic        skid_v;
  logic [31:0] skid_ir;
  logic [10:0] skid_pc;
  logic [31:0] ir_q;
  logic [10:0] pc_q;
  logic        valid_q;
  logic        advance;
  logic        imem_en;

  // Only STALL/HALT/REDIRECT reach IMEM_EN combinationally; every other
  // output is a register.
  always_comb begin
    state_nxt = state_q;
    advance   = ~valid_q | ~bus.STALL;
    // Skid full, or ROM data arriving with nowhere to go, blocks a new read.
    imem_en   = (state_q == S_RUN) & ~bus.HALT & ~bus.REDIRECT & ~skid_v &
                (advance | ~req_v);
    if (bus.REDIRECT)
      state_nxt = S_RUN;
    else if (state_q == S_RUN && bus.HALT)
      state_nxt = S_WAIT;
  end

  always_ff @(posedge CLK) begin
    if (RST) state_q <= S_RUN;
    else     state_q <= state_nxt;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      fpc     <= RESET_PC;
      req_v   <= 1'b0;
      req_pc  <= '0;
      skid_v  <= 1'b0;
      skid_ir <= '0;
      skid_pc <= '0;
      ir_q    <= '0;
      pc_q    <= '0;
      valid_q <= 1'b0;
    end else if (bus.REDIRECT) begin
      // Squash everything older than the redirect; issue resumes next cycle.
      fpc     <= bus.REDIRECT_PC;
      req_v   <= 1'b0;
      skid_v  <= 1'b0;
      valid_q <= 1'b0;
    end else if (state_q == S_WAIT || bus.HALT) begin
      // HALT means the decoder took the current output; drop the rest.
      req_v   <= 1'b0;
      skid_v  <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      req_v <= imem_en;
      if (imem_en) begin
        req_pc <= fpc;
        fpc    <= fpc + 11'd1;
      end
      if (advance) begin
        if (skid_v) begin
          ir_q    <= skid_ir;
          pc_q    <= skid_pc;
          valid_q <= 1'b1;
          // Refill behind the entry just delivered, keeping order.
          if (req_v) begin
            skid_ir <= bus.IMEM_DATA;
            skid_pc <= req_pc;
          end else begin
            skid_v  <= 1'b0;
          end
        end else if (req_v) begin
          ir_q    <= bus.IMEM_DATA;
          pc_q    <= req_pc;
          valid_q <= 1'b1;
        end else begin
          valid_q <= 1'b0;
        end
      end else if (req_v) begin
        // Stalled with a read landing: the skid is empty here because a full
        // skid suppresses issue the cycle before.
        skid_v  <= 1'b1;
        skid_ir <= bus.IMEM_DATA;
        skid_pc <= req_pc;
      end
    end
  end

  assign bus.IMEM_EN   = imem_en;
  assign bus.IMEM_ADDR = fpc;
  assign bus.IR        = ir_q;
  assign bus.PC        = pc_q;
  assign bus.VALID     = valid_q;

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;
  logic clk = 1'b0;
  logic rst, rst2;
  int   nvec = 0;
  int   nerr = 0;

  always #5 clk = ~clk;

  fetch_unit_if bus();
  fetch_unit_if bus2();

  fetch_unit u_dut (.CLK(clk), .RST(rst), .bus(bus.master));
  fetch_unit #(.RESET_PC(11'h7FE)) u_wrap (.CLK(clk), .RST(rst2), .bus(bus2.master));

  // ROM models: mem[i] = 0x1000_0000 + i, one-cycle read latency
  always @(posedge clk) if (bus.IMEM_EN)  bus.IMEM_DATA  <= 32'h1000_0000 + 32'(bus.IMEM_ADDR);
  always @(posedge clk) if (bus2.IMEM_EN) bus2.IMEM_DATA <= 32'h1000_0000 + 32'(bus2.IMEM_ADDR);

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b1; rst2 = 1'b1;
    bus.STALL = 0; bus.HALT = 0; bus.REDIRECT = 0; bus.REDIRECT_PC = '0;
    bus2.STALL = 0; bus2.HALT = 0; bus2.REDIRECT = 0; bus2.REDIRECT_PC = '0;
    tick; tick;
    nvec++; if (bus.VALID !== 1'b0) begin nerr++; $display("FAIL reset_valid: got %0h want 0", bus.VALID); end
    nvec++; if (bus.IR !== 32'h0) begin nerr++; $display("FAIL reset_ir: got %0h want 0", bus.IR); end
    nvec++; if (bus.PC !== 11'h0) begin nerr++; $display("FAIL reset_pc: got %0h want 0", bus.PC); end
    rst = 1'b0;
    #1;
    nvec++; if (bus.IMEM_EN !== 1'b1 || bus.IMEM_ADDR !== 11'h0) begin
      nerr++; $display("FAIL first_issue: got en=%0h addr=%0h want en=1 addr=0", bus.IMEM_EN, bus.IMEM_ADDR); end
    tick;
    nvec++; if (bus.VALID !== 1'b0) begin nerr++; $display("FAIL valid_early: got %0h want 0", bus.VALID); end
    tick;
    nvec++; if (bus.VALID !== 1'b1 || bus.PC !== 11'h0 || bus.IR !== 32'h1000_0000) begin
      nerr++; $display("FAIL first_valid: got v=%0h pc=%0h ir=%0h want v=1 pc=0 ir=10000000", bus.VALID, bus.PC, bus.IR); end
  endtask

  task automatic test_stream;
    for (int i = 1; i <= 4; i++) begin
      tick;
      nvec++; if (bus.VALID !== 1'b1 || bus.PC !== 11'(i) || bus.IR !== 32'h1000_0000 + 32'(i)) begin
        nerr++; $display("FAIL stream_%0d: got v=%0h pc=%0h ir=%0h want v=1 pc=%0h", i, bus.VALID, bus.PC, bus.IR, i); end
    end
  endtask

  task automatic test_stall;
    int exp_pc;
    bit found;
    tick;  // PC=5 on outputs
    bus.STALL = 1'b1;
    for (int k = 0; k < 3; k++) begin
      nvec++; if (bus.VALID !== 1'b1 || bus.PC !== 11'd5 || bus.IR !== 32'h1000_0005) begin
        nerr++; $display("FAIL stall_hold_%0d: got v=%0h pc=%0h ir=%0h want v=1 pc=5 ir=10000005", k, bus.VALID, bus.PC, bus.IR); end
      #1;
      nvec++; if (bus.IMEM_EN !== 1'b0) begin nerr++; $display("FAIL stall_en_%0d: got %0h want 0", k, bus.IMEM_EN); end
      tick;
    end
    nvec++; if (bus.VALID !== 1'b1 || bus.PC !== 11'd5) begin
      nerr++; $display("FAIL stall_hold_end: got v=%0h pc=%0h want v=1 pc=5", bus.VALID, bus.PC); end
    bus.STALL = 1'b0;
    tick;
    nvec++; if (bus.VALID !== 1'b1 || bus.PC !== 11'd6 || bus.IR !== 32'h1000_0006) begin
      nerr++; $display("FAIL skid_deliver: got v=%0h pc=%0h ir=%0h want v=1 pc=6", bus.VALID, bus.PC, bus.IR); end
    exp_pc = 7;
    found = 0;
    for (int c = 0; c < 8 && !found; c++) begin
      tick;
      if (bus.VALID === 1'b1) begin
        nvec++; if (bus.PC !== 11'(exp_pc) || bus.IR !== 32'h1000_0000 + 32'(exp_pc)) begin
          nerr++; $display("FAIL after_stall: got pc=%0h ir=%0h want pc=%0h", bus.PC, bus.IR, exp_pc); end
        if (bus.PC == 11'd8) found = 1;
        exp_pc++;
      end
    end
    nvec++; if (!found) begin nerr++; $display("FAIL reach_pc8: got timeout want pc=8"); end
  endtask

  task automatic test_halt;
    bus.HALT = 1'b1;  // PC=8 on outputs
    #1;
    nvec++; if (bus.IMEM_EN !== 1'b0) begin nerr++; $display("FAIL halt_en: got %0h want 0", bus.IMEM_EN); end
    tick;
    bus.HALT = 1'b0;
    for (int k = 0; k < 2; k++) begin
      nvec++; if (bus.VALID !== 1'b0) begin nerr++; $display("FAIL halt_valid_%0d: got %0h pc=%0h want 0", k, bus.VALID, bus.PC); end
      #1;
      nvec++; if (bus.IMEM_EN !== 1'b0) begin nerr++; $display("FAIL wait_en_%0d: got %0h want 0", k, bus.IMEM_EN); end
      tick;
    end
    bus.REDIRECT = 1'b1; bus.REDIRECT_PC = 11'h100;
    nvec++; if (bus.VALID !== 1'b0) begin nerr++; $display("FAIL halt_valid_2: got %0h want 0", bus.VALID); end
    tick;
    bus.REDIRECT = 1'b0;
    #1;
    nvec++; if (bus.IMEM_EN !== 1'b1 || bus.IMEM_ADDR !== 11'h100) begin
      nerr++; $display("FAIL redir_issue: got en=%0h addr=%0h want en=1 addr=100", bus.IMEM_EN, bus.IMEM_ADDR); end
    nvec++; if (bus.VALID !== 1'b0) begin nerr++; $display("FAIL redir_v1: got %0h want 0", bus.VALID); end
    tick;
    nvec++; if (bus.VALID !== 1'b0) begin nerr++; $display("FAIL redir_v2: got %0h want 0", bus.VALID); end
    tick;
    nvec++; if (bus.VALID !== 1'b1 || bus.PC !== 11'h100 || bus.IR !== 32'h1000_0100) begin
      nerr++; $display("FAIL redir_first: got v=%0h pc=%0h ir=%0h want v=1 pc=100", bus.VALID, bus.PC, bus.IR); end
  endtask

  task automatic test_simultaneous;
    tick;
    nvec++; if (bus.VALID !== 1'b1 || bus.PC !== 11'h101) begin nerr++; $display("FAIL stream_101: got v=%0h pc=%0h want v=1 pc=101", bus.VALID, bus.PC); end
    tick;
    nvec++; if (bus.VALID !== 1'b1 || bus.PC !== 11'h102) begin nerr++; $display("FAIL stream_102: got v=%0h pc=%0h want v=1 pc=102", bus.VALID, bus.PC); end
    bus.STALL = 1'b1;
    tick;  // skid now holds 0x103
    bus.REDIRECT = 1'b1; bus.HALT = 1'b1; bus.REDIRECT_PC = 11'h020;
    #1;
    nvec++; if (bus.IMEM_EN !== 1'b0) begin nerr++; $display("FAIL simul_en: got %0h want 0", bus.IMEM_EN); end
    tick;
    bus.REDIRECT = 1'b0; bus.HALT = 1'b0; bus.STALL = 1'b0;
    nvec++; if (bus.VALID !== 1'b0) begin nerr++; $display("FAIL simul_v1: got %0h pc=%0h want 0", bus.VALID, bus.PC); end
    #1;
    nvec++; if (bus.IMEM_EN !== 1'b1 || bus.IMEM_ADDR !== 11'h020) begin
      nerr++; $display("FAIL simul_issue: got en=%0h addr=%0h want en=1 addr=20", bus.IMEM_EN, bus.IMEM_ADDR); end
    tick;
    nvec++; if (bus.VALID !== 1'b0) begin nerr++; $display("FAIL simul_v2: got %0h pc=%0h want 0", bus.VALID, bus.PC); end
    tick;
    nvec++; if (bus.VALID !== 1'b1 || bus.PC !== 11'h020 || bus.IR !== 32'h1000_0020) begin
      nerr++; $display("FAIL simul_first: got v=%0h pc=%0h ir=%0h want v=1 pc=20", bus.VALID, bus.PC, bus.IR); end
  endtask

  task automatic test_reset_stall;
    bus.STALL = 1'b1;
    tick;  // skid fills with 0x21
    tick;
    rst = 1'b1;
    tick;
    rst = 1'b0; bus.STALL = 1'b0;
    nvec++; if (bus.VALID !== 1'b0 || bus.IR !== 32'h0 || bus.PC !== 11'h0) begin
      nerr++; $display("FAIL rst_stall_out: got v=%0h pc=%0h ir=%0h want all 0", bus.VALID, bus.PC, bus.IR); end
    #1;
    nvec++; if (bus.IMEM_EN !== 1'b1 || bus.IMEM_ADDR !== 11'h0) begin
      nerr++; $display("FAIL rst_stall_issue: got en=%0h addr=%0h want en=1 addr=0", bus.IMEM_EN, bus.IMEM_ADDR); end
    tick;
    nvec++; if (bus.VALID !== 1'b0) begin nerr++; $display("FAIL rst_stall_v1: got %0h pc=%0h want 0", bus.VALID, bus.PC); end
    tick;
    nvec++; if (bus.VALID !== 1'b1 || bus.PC !== 11'h0 || bus.IR !== 32'h1000_0000) begin
      nerr++; $display("FAIL rst_stall_first: got v=%0h pc=%0h ir=%0h want v=1 pc=0", bus.VALID, bus.PC, bus.IR); end
  endtask

  task automatic test_wrap;
    logic [10:0] exp_pc [4];
    bit found;
    exp_pc[0] = 11'h7FE; exp_pc[1] = 11'h7FF; exp_pc[2] = 11'h000; exp_pc[3] = 11'h001;
    rst2 = 1'b0;
    found = 0;
    for (int c = 0; c < 6 && !found; c++) begin
      tick;
      if (bus2.VALID === 1'b1) found = 1;
    end
    nvec++; if (!found) begin nerr++; $display("FAIL wrap_start: got timeout want valid"); end
    for (int i = 0; i < 4; i++) begin
      if (i > 0) tick;
      nvec++; if (bus2.VALID !== 1'b1 || bus2.PC !== exp_pc[i] || bus2.IR !== 32'h1000_0000 + 32'(exp_pc[i])) begin
        nerr++; $display("FAIL wrap_%0d: got v=%0h pc=%0h ir=%0h want v=1 pc=%0h", i, bus2.VALID, bus2.PC, bus2.IR, exp_pc[i]); end
    end
  endtask

  initial begin
    test_reset;
    test_stream;
    test_stall;
    test_halt;
    test_simultaneous;
    test_reset_stall;
    test_wrap;
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got no finish want finish before 100000");
    $fatal(1);
  end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch stage, directly upstream of the decoder. It holds the fetch PC and drives a synchronous 1-cycle-latency instruction ROM. It presents `IR`, `PC` and `VALID` to the decoder and holds them while the decoder signals `STALL`. When the decoder signals `HALT` (control transfer or halt) it stops and squashes fetch, then resumes only on `REDIRECT` from the execute stage.

## Interface
- `RESET_PC`, default 11'd0: fetch address after reset.
- `CLK` input 1: clock, all state updates on rising edge.
- `RST` input 1: synchronous, active-high reset.
- `IMEM_EN` output 1: ROM read enable (combinational).
- `IMEM_ADDR` output 11: ROM read address (equals fetch PC register `FPC`).
- `IMEM_DATA` input 32: ROM data, valid the cycle after an `IMEM_EN` cycle.
- `IR` output 32: instruction to decoder (registered).
- `PC` output 11: address of `IR` (registered).
- `VALID` output 1: `IR`/`PC` hold a live instruction (registered).
- `STALL` input 1: decoder cannot accept; hold outputs.
- `HALT` input 1: decoder consumed a control-transfer/HLT, or is stopped; stop fetching.
- `REDIRECT` input 1: execute-stage target valid this cycle.
- `REDIRECT_PC` input 11: new fetch address.

## Operation
- Internal state:
  - `FPC`[10:0].
  - State `RUN`/`WAIT`.
  - `REQ_V`/`REQ_PC`: a read is in flight, data on `IMEM_DATA` this cycle.
  - One-entry skid buffer `SKID_V`/`SKID_IR`/`SKID_PC`.
- Reset values:
  - `FPC`=`RESET_PC`, state=`RUN`.
  - `REQ_V`=`SKID_V`=0.
  - `IR`=0, `PC`=0, `VALID`=0.
- `advance` = ~`VALID` | ~`STALL`.
- Candidate source: the skid buffer if `SKID_V`, else ROM data if `REQ_V`, else none.
- On `advance`:
  - Output register loads the candidate (`VALID`=1), or `VALID`=0 if there is no candidate.
  - If the skid buffer was the source and `REQ_V`, the ROM data moves into the skid buffer.
- If not `advance` and `REQ_V`: ROM data is captured into the skid buffer, which is guaranteed empty.
- `IMEM_EN` = (state==`RUN`) & ~`HALT` & ~`REDIRECT` & ~`SKID_V` & (`advance` | ~`REQ_V`).
  - On issue: `REQ_V`<=1, `REQ_PC`<=`FPC`, `FPC`<=`FPC`+1 (11-bit wrap, 2047→0).
  - Otherwise `REQ_V`<=0.
- `HALT` (any cycle, state `RUN`, no `REDIRECT`):
  - The current output is considered consumed.
  - `VALID`<=0, `SKID_V`<=0, `REQ_V`<=0, state<=`WAIT`, no issue.
- State `WAIT`:
  - No issue.
  - `VALID` stays 0.
  - ROM data is ignored.
- `REDIRECT` (any state, priority over `HALT` and `STALL`):
  - `FPC`<=`REDIRECT_PC`, state<=`RUN`.
  - `VALID`/`SKID_V`/`REQ_V`<=0 (in-flight data squashed).
  - No issue this cycle.
- A decoder that stays stopped after HLT keeps `HALT` high. The block then remains in `WAIT` until `REDIRECT` or `RST`.
- `RST` has priority over every other input in every state.

## Timing
- After `RST` falls, `IMEM_EN`=1 with `IMEM_ADDR`=`RESET_PC` in the first cycle.
- `VALID`=1 with `IR`=mem[`RESET_PC`] from 2 cycles after issue.
- Steady state: one instruction per cycle, `PC` incrementing by 1.
- Redirect latency:
  - `REDIRECT` in cycle t, issue at t+1.
  - First redirected instruction on `VALID` at t+3.
- Stall:
  - `IR`/`PC`/`VALID` are bit-stable while `STALL`=1 & `VALID`=1.
  - At most one further read completes into the skid buffer, then `IMEM_EN`=0.
  - On `STALL` release, the skid entry is delivered the next cycle with no lost or duplicated instruction.
- `HALT` in cycle t:
  - `VALID`=0 from t+1.
  - `IMEM_EN`=0 from t onward.
- No combinational path from `IMEM_DATA` to any output.
- The only combinational paths from `STALL`/`HALT`/`REDIRECT` are to `IMEM_EN`.

## Test plan
- **Reset and stream:** ROM mem[i]=32'h1000_0000+i, `RST` high for 2 cycles then low, `STALL`=0, `HALT`=0.
  - Required: `VALID` rises 2 cycles after the first issue.
  - Required: `IR`/`PC` sequence is 0x10000000/0, 0x10000001/1, … with no gaps.
- **Stall mid-stream:** assert `STALL` for 3 cycles while `PC`=5.
  - Required: `IR`/`PC` held at 5 for all 3 cycles.
  - Required: `IMEM_EN` drops after one extra read.
  - Required: after release, the sequence continues 6, 7, … with no duplicates.
- **Halt then redirect:** `HALT` pulse while `PC`=8, then `REDIRECT`=1 with `REDIRECT_PC`=11'h100 three cycles later.
  - Required: `VALID`=0 the next cycle.
  - Required: instructions 9 and 10 never appear on the outputs.
  - Required: `PC`=0x100 is valid 3 cycles after `REDIRECT`.
- **Simultaneous `REDIRECT`+`HALT`+`STALL`:** `REDIRECT_PC`=11'h020.
  - Required: redirect wins.
  - Required: the next valid `PC` is 0x020, and nothing older is delivered.
- **Wrap-around:** `RESET_PC`=11'h7FE.
  - Required: `PC` sequence is 0x7FE, 0x7FF, 0x000, 0x001.
- **Reset mid-stall:** assert `RST` while `STALL`=1 and `SKID_V`=1.
  - Required: next cycle `VALID`=0, `IR`=0, `PC`=0.
  - Required: fetch restarts at `RESET_PC`, and the skid contents are never delivered.
